// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO, depth 2**ADDR_BITS.
// Ports: clk, rst (async active-low), enq/deq requests, data_in,
//   registered data_out, full/empty flags, usedw count, perc_full.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq,
    input  logic                  deq,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_BITS:0]    usedw,
    output logic [6:0]            perc_full
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CW    = ADDR_BITS + 1;
    localparam int PW    = ADDR_BITS + 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic [PW-1:0]        prod;
    logic [6:0]           perc_nxt;

    logic rd_ok;
    logic wr_ok;

    // A read frees a slot in the same cycle, so a full FIFO
    // still accepts a write when a read is accepted alongside.
    assign rd_ok = deq & ~empty;
    assign wr_ok = enq & (~full | rd_ok);

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            (wr_ok & ~rd_ok): count_nxt = count + CW'(1);
            (rd_ok & ~wr_ok): count_nxt = count - CW'(1);
            default:          count_nxt = count;
        endcase
    end

    // Product is wide enough for DEPTH*100; the divide by DEPTH
    // is a plain shift, and the result never exceeds 100.
    always_comb begin
        prod     = PW'(count_nxt) * PW'(100);
        perc_nxt = 7'(prod >> ADDR_BITS);
    end

    // Storage is never reset; its contents are don't-care.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            usedw     <= '0;
            perc_full <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + ADDR_BITS'(1);
                data_out <= mem[rd_ptr];
            end
            count     <= count_nxt;
            full      <= (count_nxt == CW'(DEPTH));
            empty     <= (count_nxt == '0);
            usedw     <= count_nxt;
            perc_full <= perc_nxt;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: checks sync_fifo against a queue model with a vector
// table plus fill/overflow, wrap-around and async-reset sequences.
module tb_sync_fifo;

    localparam int DW    = 32;
    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;

    logic          clk;
    logic          rst;
    logic          enq;
    logic          deq;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [AB:0]   usedw;
    logic [6:0]    perc_full;

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .deq       (deq),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .usedw     (usedw),
        .perc_full (perc_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_dout;

    typedef struct {
        logic          e;
        logic          d;
        logic [DW-1:0] din;
        int            exp_used;
        logic [DW-1:0] exp_dout;
        logic          exp_empty;
        logic          exp_full;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = sb_q.size();
        check({tag, ".data_out"}, longint'(data_out), longint'(exp_dout));
        check({tag, ".usedw"}, longint'(usedw), longint'(sz));
        check({tag, ".empty"}, longint'(empty), longint'(sz == 0));
        check({tag, ".full"}, longint'(full), longint'(sz == DEPTH));
        check({tag, ".perc"}, longint'(perc_full),
              longint'((sz * 100) / DEPTH));
    endtask

    // Drive one cycle; the scoreboard pops the expected word when a
    // read is accepted and pushes data_in when a write is accepted.
    task automatic step(input logic e, input logic d,
                        input logic [DW-1:0] din, input string tag);
        logic rd;
        @(negedge clk);
        enq     = e;
        deq     = d;
        data_in = din;
        rd = d && (sb_q.size() > 0);
        if (rd) exp_dout = sb_q.pop_front();
        if (e && (sb_q.size() < DEPTH || rd)) sb_q.push_back(din);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        exp_dout = '0;
        enq      = 1'b0;
        deq      = 1'b0;
        data_in  = '0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1555, 1, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0AAA, 2, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0, 1, 32'h0000_1555, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 0, 32'h0000_0AAA, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0, 0, 32'h0000_0AAA, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 0, 32'h0000_0AAA, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_1234, 1, 32'h0000_0AAA, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'h0, 0, 32'h0000_1234, 1'b1, 1'b0};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset.data_out", longint'(data_out), 0);
        check("reset.empty", longint'(empty), 1);
        check("reset.full", longint'(full), 0);
        check("reset.usedw", longint'(usedw), 0);
        check("reset.perc", longint'(perc_full), 0);

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].e, vecs[i].d, vecs[i].din, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_usedw", i), longint'(usedw),
                  longint'(vecs[i].exp_used));
            check($sformatf("vec%0d.tbl_dout", i), longint'(data_out),
                  longint'(vecs[i].exp_dout));
            check($sformatf("vec%0d.tbl_empty", i), longint'(empty),
                  longint'(vecs[i].exp_empty));
            check($sformatf("vec%0d.tbl_full", i), longint'(full),
                  longint'(vecs[i].exp_full));
        end

        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
        check("fill.full", longint'(full), 1);
        check("fill.usedw", longint'(usedw), DEPTH);
        check("fill.perc", longint'(perc_full), 100);

        step(1'b1, 1'b0, 32'hDEAD_BEEF, "ovf");
        check("ovf.usedw", longint'(usedw), DEPTH);

        step(1'b1, 1'b1, DW'(DEPTH), "fullrw");
        check("fullrw.dout", longint'(data_out), 0);
        check("fullrw.full", longint'(full), 1);

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            check("drain.order", longint'(data_out), longint'(i + 1));
        end
        check("drain.empty", longint'(empty), 1);

        for (int i = 0; i < 700; i++) begin
            step(1'b1, 1'b0, DW'(32'h1000 + i), "adv_w");
            step(1'b0, 1'b1, '0, "adv_r");
        end
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 1'b0, DW'(32'h2000 + i), "wrap_w");
        end
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 1'b1, DW'(32'h3000 + i), "wrap_rw");
        end
        check("wrap.usedw", longint'(usedw), 500);
        check("wrap.perc", longint'(perc_full), 48);

        while (sb_q.size() > 0) step(1'b0, 1'b1, '0, "wrap_drain");

        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, DW'(32'h4000 + i), "pre_rst_w");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "pre_rst_r");
        check("pre_rst.usedw", longint'(usedw), 37);

        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst.data_out", longint'(data_out), 0);
        check("arst.empty", longint'(empty), 1);
        check("arst.full", longint'(full), 0);
        check("arst.usedw", longint'(usedw), 0);
        check("arst.perc", longint'(perc_full), 0);
        sb_q.delete();
        exp_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        step(1'b1, 1'b0, 32'hCAFE_0001, "post_rst_w");
        step(1'b0, 1'b1, '0, "post_rst_r");
        check("post_rst.dout", longint'(data_out), 32'hCAFE_0001);
        step(1'b0, 1'b0, '0, "post_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
